// File: rtl/spi_pixel_loader_if.sv
// Write-only memory port bundle used for the picture and background
// dual-port memories; the loader drives it as master.
interface spi_pixel_loader_if #(
    parameter int unsigned AW = 11
);
    logic [AW-1:0] address;
    logic          chipselect;
    logic          write;
    logic          clken;
    logic [15:0]   writedata;
    logic [1:0]    byteenable;

    modport master (
        output address,
        output chipselect,
        output write,
        output clken,
        output writedata,
        output byteenable
    );

    modport slave (
        input address,
        input chipselect,
        input write,
        input clken,
        input writedata,
        input byteenable
    );
endinterface

// File: rtl/spi_pixel_loader.sv
// Turns the SPI slave byte stream into pixel writes: 2-byte start address
// header, then 16-bit pixels written at an auto-incrementing wrapping address.
module spi_pixel_loader #(
    parameter int unsigned PIC_AW    = 11,
    parameter int unsigned BG_AW     = 13,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [7:0]                 spi_data,
    input  logic                       spi_data_en,
    input  logic [7:0]                 spi_config,
    spi_pixel_loader_if.master         pic,
    spi_pixel_loader_if.master         bg,
    output logic                       busy,
    output logic [13:0]                pixel_count,
    output logic                       frame_done
);

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned PIX_W  = 16;
    localparam int unsigned CNT_W  = 14;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [1:0] MODE_PIC = 2'b01;
    localparam logic [1:0] MODE_BG  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_PIX_A,
        S_PIX_B
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [1:0]          run_mode_q, run_mode_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          byte_q, byte_d;
    logic [PIC_AW-1:0]   pic_address_q, pic_address_d;
    logic                pic_wr_q, pic_wr_d;
    logic [PIX_W-1:0]    pic_data_q, pic_data_d;
    logic [BG_AW-1:0]    bg_address_q, bg_address_d;
    logic                bg_wr_q, bg_wr_d;
    logic [PIX_W-1:0]    bg_data_q, bg_data_d;
    logic                clken_q, clken_d;
    logic [1:0]          be_q, be_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                frame_done_q, frame_done_d;

    logic                abort;
    logic [PIX_W-1:0]    pixel;
    logic                unused_cfg;

    assign unused_cfg = ^spi_config[7:2];

    // Leaving the latched mode while busy ends the frame, dropping any half pixel.
    assign abort = (state_q != S_IDLE) && (mode_q != run_mode_q);
    assign pixel = MSB_FIRST ? {byte_q, spi_data} : {spi_data, byte_q};

    always_comb begin
        state_d       = state_q;
        mode_d        = spi_config[1:0];
        run_mode_d    = run_mode_q;
        addr_d        = addr_q;
        byte_d        = byte_q;
        pic_address_d = pic_address_q;
        pic_wr_d      = 1'b0;
        pic_data_d    = pic_data_q;
        bg_address_d  = bg_address_q;
        bg_wr_d       = 1'b0;
        bg_data_d     = bg_data_q;
        clken_d       = 1'b1;
        be_d          = 2'b11;
        count_d       = count_q;
        frame_done_d  = 1'b0;

        if (state_q == S_IDLE) begin
            if ((mode_q == MODE_PIC) || (mode_q == MODE_BG)) begin
                state_d    = S_ADDR_HI;
                run_mode_d = mode_q;
                count_d    = '0;
            end
        end else if (abort) begin
            state_d      = S_IDLE;
            frame_done_d = (count_q != '0);
        end else if (spi_data_en) begin
            unique case (state_q)
                S_ADDR_HI: begin
                    addr_d[15:8] = spi_data;
                    state_d      = S_ADDR_LO;
                end
                S_ADDR_LO: begin
                    addr_d[7:0] = spi_data;
                    state_d     = S_PIX_A;
                end
                S_PIX_A: begin
                    byte_d  = spi_data;
                    state_d = S_PIX_B;
                end
                S_PIX_B: begin
                    if (run_mode_q == MODE_BG) begin
                        bg_wr_d      = 1'b1;
                        bg_address_d = addr_q[BG_AW-1:0];
                        bg_data_d    = pixel;
                    end else begin
                        pic_wr_d      = 1'b1;
                        pic_address_d = addr_q[PIC_AW-1:0];
                        pic_data_d    = pixel;
                    end
                    // Full 16-bit increment; truncation at the port gives the wrap.
                    addr_d  = addr_q + ADDR_W'(1);
                    count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
                    state_d = S_PIX_A;
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            mode_q        <= 2'b00;
            run_mode_q    <= 2'b00;
            addr_q        <= '0;
            byte_q        <= '0;
            pic_address_q <= '0;
            pic_wr_q      <= 1'b0;
            pic_data_q    <= '0;
            bg_address_q  <= '0;
            bg_wr_q       <= 1'b0;
            bg_data_q     <= '0;
            clken_q       <= 1'b1;
            be_q          <= 2'b11;
            busy_q        <= 1'b0;
            count_q       <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            run_mode_q    <= run_mode_d;
            addr_q        <= addr_d;
            byte_q        <= byte_d;
            pic_address_q <= pic_address_d;
            pic_wr_q      <= pic_wr_d;
            pic_data_q    <= pic_data_d;
            bg_address_q  <= bg_address_d;
            bg_wr_q       <= bg_wr_d;
            bg_data_q     <= bg_data_d;
            clken_q       <= clken_d;
            be_q          <= be_d;
            busy_q        <= busy_d;
            count_q       <= count_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign pic.address    = pic_address_q;
    assign pic.chipselect = pic_wr_q;
    assign pic.write      = pic_wr_q;
    assign pic.clken      = clken_q;
    assign pic.writedata  = pic_data_q;
    assign pic.byteenable = be_q;

    assign bg.address     = bg_address_q;
    assign bg.chipselect  = bg_wr_q;
    assign bg.write       = bg_wr_q;
    assign bg.clken       = clken_q;
    assign bg.writedata   = bg_data_q;
    assign bg.byteenable  = be_q;

    assign busy        = busy_q;
    assign pixel_count = count_q;
    assign frame_done  = frame_done_q;

endmodule
